// File: rtl/score_ctrl.sv
// Pong-style score keeper: counts goals, pauses after each one, serves the ball and declares a winner.
// Optional digit blinking during the post-goal pause and game over is enabled with `define SCORE_BLINK_EN.
module score_ctrl #(
    parameter int WIN_SCORE    = 9,
    parameter int HOLD_FRAMES  = 120,
    parameter int BLINK_FRAMES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       goal_p1,
    input  logic       goal_p2,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic       vis_p1,
    output logic       vis_p2,
    output logic       serve,
    output logic       serve_dir,
    output logic       game_over,
    output logic       winner
);

    typedef enum logic [1:0] {IDLE, PLAY, HOLD, GAME_OVER} state_t;

    localparam logic [3:0] WIN       = 4'(WIN_SCORE);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);

    state_t     state, state_next;
    logic [3:0] cnt_p1, cnt_p2, cnt_p1_next, cnt_p2_next;
    logic       scorer, scorer_next;
    logic [7:0] hold_cnt, hold_cnt_next;
    logic       serve_next, serve_dir_next, winner_next;
    logic       clear_disp;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt_p1    <= 4'd0;
            cnt_p2    <= 4'd0;
            scorer    <= 1'b0;
            hold_cnt  <= 8'd0;
            serve     <= 1'b0;
            serve_dir <= 1'b0;
            winner    <= 1'b0;
            score_p1  <= 4'd0;
            score_p2  <= 4'd0;
        end else begin
            state     <= state_next;
            cnt_p1    <= cnt_p1_next;
            cnt_p2    <= cnt_p2_next;
            scorer    <= scorer_next;
            hold_cnt  <= hold_cnt_next;
            serve     <= serve_next;
            serve_dir <= serve_dir_next;
            winner    <= winner_next;
            // Displayed digits only change on a frame boundary so the renderer never tears.
            if (clear_disp) begin
                score_p1 <= 4'd0;
                score_p2 <= 4'd0;
            end else if (frame_tick) begin
                score_p1 <= cnt_p1;
                score_p2 <= cnt_p2;
            end
        end
    end

    always_comb begin
        state_next     = state;
        cnt_p1_next    = cnt_p1;
        cnt_p2_next    = cnt_p2;
        scorer_next    = scorer;
        hold_cnt_next  = hold_cnt;
        serve_next     = 1'b0;
        serve_dir_next = serve_dir;
        winner_next    = winner;
        clear_disp     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next     = PLAY;
                    serve_next     = 1'b1;
                    serve_dir_next = 1'b0;
                end
            end
            PLAY: begin
                // goal_p1 wins a same-cycle tie; the simultaneous goal_p2 is dropped.
                if (goal_p1) begin
                    if (cnt_p1 < WIN) cnt_p1_next = cnt_p1 + 4'd1;
                    scorer_next   = 1'b0;
                    hold_cnt_next = 8'd0;
                    state_next    = HOLD;
                end else if (goal_p2) begin
                    if (cnt_p2 < WIN) cnt_p2_next = cnt_p2 + 4'd1;
                    scorer_next   = 1'b1;
                    hold_cnt_next = 8'd0;
                    state_next    = HOLD;
                end
            end
            HOLD: begin
                if (frame_tick) begin
                    hold_cnt_next = hold_cnt + 8'd1;
                    if (hold_cnt == HOLD_LAST) begin
                        if ((scorer ? cnt_p2 : cnt_p1) == WIN) begin
                            state_next  = GAME_OVER;
                            winner_next = scorer;
                        end else begin
                            state_next     = PLAY;
                            serve_next     = 1'b1;
                            serve_dir_next = scorer;
                        end
                    end
                end
            end
            GAME_OVER: begin
                if (start) begin
                    cnt_p1_next    = 4'd0;
                    cnt_p2_next    = 4'd0;
                    clear_disp     = 1'b1;
                    state_next     = PLAY;
                    serve_next     = 1'b1;
                    serve_dir_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign game_over = (state == GAME_OVER);

`ifdef SCORE_BLINK_EN
    localparam logic [7:0] BLINK_DIV  = 8'(BLINK_FRAMES);
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    logic [7:0] blink_cnt;
    logic       blink_phase;
    logic [7:0] hold_div;

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt   <= 8'd0;
            blink_phase <= 1'b1;
        end else if (frame_tick) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= 8'd0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 8'd1;
            end
        end
    end

    assign hold_div = hold_cnt / BLINK_DIV;

    // Only the scorer (in HOLD) or the winner (in GAME_OVER) ever blinks.
    always_comb begin
        vis_p1 = 1'b1;
        vis_p2 = 1'b1;
        case (state)
            HOLD: begin
                if (scorer) vis_p2 = ~hold_div[0];
                else        vis_p1 = ~hold_div[0];
            end
            GAME_OVER: begin
                if (winner) vis_p2 = blink_phase;
                else        vis_p1 = blink_phase;
            end
            default: ;
        endcase
    end
`else
    assign vis_p1 = 1'b1;
    assign vis_p2 = 1'b1;
`endif

endmodule

// File: tb/tb_score_ctrl.sv
// Scoreboard bench for score_ctrl: expected serve events are queued by the stimulus thread and
// popped by a monitor whenever the DUT pulses serve; static outputs are checked directly.
module tb_score_ctrl;

    logic       clk;
    logic       reset;
    logic       frame_tick;
    logic       start;
    logic       goal_p1;
    logic       goal_p2;
    logic [3:0] score_p1;
    logic [3:0] score_p2;
    logic       vis_p1;
    logic       vis_p2;
    logic       serve;
    logic       serve_dir;
    logic       game_over;
    logic       winner;

    typedef struct packed {
        logic       dir;
        logic [3:0] s1;
        logic [3:0] s2;
    } serve_exp_t;

    serve_exp_t exp_q[$];
    serve_exp_t mon_got;
    serve_exp_t mon_want;
    logic       prev_serve;
    int         compared;
    int         failed;

    score_ctrl #(
        .WIN_SCORE(9),
        .HOLD_FRAMES(120),
        .BLINK_FRAMES(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .frame_tick(frame_tick),
        .start(start),
        .goal_p1(goal_p1),
        .goal_p2(goal_p2),
        .score_p1(score_p1),
        .score_p2(score_p2),
        .vis_p1(vis_p1),
        .vis_p2(vis_p2),
        .serve(serve),
        .serve_dir(serve_dir),
        .game_over(game_over),
        .winner(winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every serve pulse must match the oldest queued expectation and never repeat back to back.
    always @(negedge clk) begin
        if (serve === 1'b1) begin
            compared++;
            if (prev_serve === 1'b1) begin
                failed++;
                $display("[TB] FAIL serve_consecutive: got serve high two cycles in a row, required single-cycle pulse");
            end else if (exp_q.size() == 0) begin
                failed++;
                $display("[TB] FAIL serve_unexpected: got serve=1 dir=%0d, required no serve", serve_dir);
            end else begin
                mon_want = exp_q.pop_front();
                mon_got  = {serve_dir, score_p1, score_p2};
                if (mon_got !== mon_want)
                    begin
                        failed++;
                        $display("[TB] FAIL serve_event: got dir=%0d scores=%0d/%0d, required dir=%0d scores=%0d/%0d",
                                 mon_got.dir, mon_got.s1, mon_got.s2, mon_want.dir, mon_want.s1, mon_want.s2);
                    end
            end
        end
        prev_serve = serve;
    end

    task automatic applyStimulus(input logic s, input logic g1, input logic g2, input logic ft);
        start      = s;
        goal_p1    = g1;
        goal_p2    = g2;
        frame_tick = ft;
        @(posedge clk);
        #1;
        start      = 1'b0;
        goal_p1    = 1'b0;
        goal_p2    = 1'b0;
        frame_tick = 1'b0;
    endtask

    task automatic frameTicks(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        compared++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
        end
    endtask

    task automatic expectServe(input logic dir, input logic [3:0] s1, input logic [3:0] s2);
        serve_exp_t e;
        e.dir = dir;
        e.s1  = s1;
        e.s2  = s2;
        exp_q.push_back(e);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_score_p1"}, 8'(score_p1), 8'd0);
        checkOutput({tag, "_score_p2"}, 8'(score_p2), 8'd0);
        checkOutput({tag, "_serve"}, 8'(serve), 8'd0);
        checkOutput({tag, "_serve_dir"}, 8'(serve_dir), 8'd0);
        checkOutput({tag, "_game_over"}, 8'(game_over), 8'd0);
        checkOutput({tag, "_winner"}, 8'(winner), 8'd0);
        checkOutput({tag, "_vis_p1"}, 8'(vis_p1), 8'd1);
        checkOutput({tag, "_vis_p2"}, 8'(vis_p2), 8'd1);
    endtask

    initial begin
        logic blink_on;
`ifdef SCORE_BLINK_EN
        blink_on = 1'b1;
`else
        blink_on = 1'b0;
`endif
        compared   = 0;
        failed     = 0;
        prev_serve = 1'b0;
        reset      = 1'b1;
        start      = 1'b0;
        goal_p1    = 1'b0;
        goal_p2    = 1'b0;
        frame_tick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        checkResetState("reset");

        // Start from IDLE serves toward player 1 with a 0/0 board.
        expectServe(1'b0, 4'd0, 4'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("serve_single_cycle", 8'(serve), 8'd0);

        // Player 2 scores; digits update only on the next frame tick.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("p2_before_tick", 8'(score_p2), 8'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("p2_after_tick", 8'(score_p2), 8'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        expectServe(1'b1, 4'd0, 4'd1);
        frameTicks(119);
        checkOutput("p2_hold_done_game_over", 8'(game_over), 8'd0);

        // Simultaneous goals: p1 takes it; later p2 pulse during HOLD is ignored.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("hold_vis_p1_%0d", i), 8'(vis_p1),
                        (blink_on && i >= 8) ? 8'd0 : 8'd1);
            checkOutput($sformatf("hold_vis_p2_%0d", i), 8'(vis_p2), 8'd1);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        end
        checkOutput("tie_score_p1", 8'(score_p1), 8'd1);
        checkOutput("tie_score_p2", 8'(score_p2), 8'd1);
        expectServe(1'b0, 4'd1, 4'd1);
        frameTicks(104);

        // Run player 1 up to 8 points.
        for (int k = 2; k <= 8; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
            expectServe(1'b0, 4'(k), 4'd1);
            frameTicks(120);
        end
        checkOutput("p1_at_eight", 8'(score_p1), 8'd8);

        // Winning goal: no serve, game over with player 1 as winner.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        frameTicks(120);
        checkOutput("win_game_over", 8'(game_over), 8'd1);
        checkOutput("win_winner", 8'(winner), 8'd0);
        checkOutput("win_score_p1", 8'(score_p1), 8'd9);
        checkOutput("win_score_p2", 8'(score_p2), 8'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("goal_in_game_over", 8'(score_p2), 8'd1);

        // Restart from GAME_OVER clears the board and serves toward player 1.
        expectServe(1'b0, 4'd0, 4'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("restart_game_over", 8'(game_over), 8'd0);
        checkOutput("restart_score_p1", 8'(score_p1), 8'd0);

        // Reset in the middle of a hold returns everything to IDLE values.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        frameTicks(50);
        checkOutput("mid_hold_score_p1", 8'(score_p1), 8'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkResetState("mid_hold_reset");
        frameTicks(130);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("goal_in_idle", 8'(score_p1), 8'd0);

        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("serve_queue_drained", 8'(exp_q.size()), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
